// File: rtl/attopu_pkg.sv
// rtl/attopu_pkg.sv - shared state encoding and opcode constants for the attopu core
package attopu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  localparam logic [2:0] OP_ALU = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_LDR = 3'b011;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_BRZ = 3'b110;
  localparam logic [2:0] OP_BRR = 3'b111;

  localparam logic [2:0] OP_ILL0 = 3'b010;
  localparam logic [2:0] OP_ILL1 = 3'b100;

  function automatic logic is_illegal_op(input logic [2:0] op);
    return (op == OP_ILL0) || (op == OP_ILL1);
  endfunction

endpackage

// File: rtl/attopu_mem_timer.sv
// rtl/attopu_mem_timer.sv - wait-cycle counter for a memory request; expired on its last allowed cycle
module attopu_mem_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == W'(TIMEOUT - 1));

  // Saturates at the expiry value so a stalled owner cannot wrap it back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/attopu_sequencer.sv
// rtl/attopu_sequencer.sv - multi-cycle fetch/decode/execute/memory control FSM for the attopu core
module attopu_sequencer
  import attopu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic [2:0]       opcode,
  input  logic             dec_regFileWE,
  input  logic             dec_memWE,
  input  logic             dec_regDataInSource,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_en,
  output logic             rf_we,
  output logic             busy,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             tmr_clear, tmr_count, tmr_expired;

  attopu_mem_timer #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_mem_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .count  (tmr_count),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    retired_d    = retired_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    rf_we        = 1'b0;
    tmr_count    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run && !halt_req) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        // An ack on the expiry cycle still completes the fetch normally.
        if (mem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (tmr_expired) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          tmr_count = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_illegal_op(opcode)) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (dec_memWE || dec_regDataInSource) begin
          state_d = S_MEM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rf_we     = dec_regFileWE;
        pc_en     = 1'b1;
        retired_d = retired_q + CNT_W'(1);
        state_d   = halt_req ? S_IDLE : S_FETCH;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_memWE;
        if (mem_ack) begin
          rf_we     = dec_regDataInSource && (opcode != OP_ST);
          pc_en     = 1'b1;
          retired_d = retired_q + CNT_W'(1);
          state_d   = halt_req ? S_IDLE : S_FETCH;
        end else if (tmr_expired) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          tmr_count = 1'b1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    tmr_clear = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;

endmodule
